// File: rtl/lc3b_fetch_stage.sv
// rtl/lc3b_fetch_stage.sv - LC-3b pipelined core instruction fetch stage
//
// Owns the PC, runs the instruction-memory request/response handshake and
// fills the IF/ID slot consumed by decode. Handles decode stalls, redirects
// (flush + refetch) and squashes responses to requests made obsolete by a
// redirect.
//
// Ports:
//   clk, reset           clock, asynchronous active-high reset
//   stall                decode cannot accept the IF/ID slot this cycle
//   redirect/redirect_pc resolved control transfer and its target
//   imem_read/address    instruction read request and address
//   imem_resp/rdata      read completion and instruction word
//   if_valid, if_ir, if_pc, if_pc_plus2, if_opcode, if_bits4_5_11
//                        IF/ID slot contents and pre-sliced control ROM bits
//   perf_bubbles, perf_discards (only with LC3B_FETCH_PERF_EN defined)
//                        saturating bubble and dropped-response counters
//
// Build option: LC3B_FETCH_PERF_EN adds the performance counters.

module lc3b_fetch_stage #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect,
  input  logic [15:0] redirect_pc,
  output logic        imem_read,
  output logic [15:0] imem_address,
  input  logic        imem_resp,
  input  logic [15:0] imem_rdata,
  output logic        if_valid,
  output logic [15:0] if_ir,
  output logic [15:0] if_pc,
  output logic [15:0] if_pc_plus2,
  output logic [3:0]  if_opcode,
  output logic [2:0]  if_bits4_5_11
`ifdef LC3B_FETCH_PERF_EN
  ,
  output logic [31:0] perf_bubbles,
  output logic [31:0] perf_discards
`endif
);

  localparam logic [15:0] RESET_PC_ALIGNED = RESET_PC & ~16'h0001;

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_HOLD,
    S_DISCARD
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] fetch_pc_q, fetch_pc_d;
  logic [15:0] pending_pc_q, pending_pc_d;
  logic [15:0] hold_ir_q, hold_ir_d;
  logic [15:0] hold_pc_q, hold_pc_d;
  logic        slot_valid_q, slot_valid_d;
  logic [15:0] slot_ir_q, slot_ir_d;
  logic [15:0] slot_pc_q, slot_pc_d;
  logic [15:0] slot_pc_plus2_q, slot_pc_plus2_d;

  logic        load_en;
  logic [15:0] load_ir;
  logic [15:0] load_pc;
  logic        drop;
  logic [15:0] target_pc;
  logic [15:0] fetch_pc_next;

  assign target_pc     = redirect_pc & ~16'h0001;
  assign fetch_pc_next = fetch_pc_q + 16'd2;

  always_comb begin
    state_d      = state_q;
    fetch_pc_d   = fetch_pc_q;
    pending_pc_d = pending_pc_q;
    hold_ir_d    = hold_ir_q;
    hold_pc_d    = hold_pc_q;
    load_en      = 1'b0;
    load_ir      = imem_rdata;
    load_pc      = fetch_pc_q;
    drop         = 1'b0;

    case (state_q)
      S_IDLE: begin
        state_d = S_FETCH;
        if (redirect) fetch_pc_d = target_pc;
      end
      S_FETCH: begin
        if (redirect && imem_resp) begin
          // Response belongs to the squashed path; refetch at once.
          drop       = 1'b1;
          fetch_pc_d = target_pc;
        end else if (redirect) begin
          pending_pc_d = target_pc;
          state_d      = S_DISCARD;
        end else if (imem_resp && (!slot_valid_q || !stall)) begin
          load_en    = 1'b1;
          fetch_pc_d = fetch_pc_next;
        end else if (imem_resp) begin
          hold_ir_d  = imem_rdata;
          hold_pc_d  = fetch_pc_q;
          fetch_pc_d = fetch_pc_next;
          state_d    = S_HOLD;
        end
      end
      S_HOLD: begin
        if (redirect) begin
          fetch_pc_d = target_pc;
          state_d    = S_FETCH;
        end else if (!stall) begin
          load_en = 1'b1;
          load_ir = hold_ir_q;
          load_pc = hold_pc_q;
          state_d = S_FETCH;
        end
      end
      S_DISCARD: begin
        if (redirect) pending_pc_d = target_pc;
        if (imem_resp) begin
          // A redirect landing with the squashed response wins over pending_pc.
          drop       = 1'b1;
          fetch_pc_d = redirect ? target_pc : pending_pc_q;
          state_d    = S_FETCH;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    slot_valid_d    = slot_valid_q;
    slot_ir_d       = slot_ir_q;
    slot_pc_d       = slot_pc_q;
    slot_pc_plus2_d = slot_pc_plus2_q;
    if (redirect) begin
      slot_valid_d = 1'b0;
    end else if (load_en) begin
      slot_valid_d    = 1'b1;
      slot_ir_d       = load_ir;
      slot_pc_d       = load_pc;
      slot_pc_plus2_d = load_pc + 16'd2;
    end else if (slot_valid_q && !stall) begin
      slot_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q         <= S_IDLE;
      fetch_pc_q      <= RESET_PC_ALIGNED;
      pending_pc_q    <= 16'h0000;
      hold_ir_q       <= 16'h0000;
      hold_pc_q       <= 16'h0000;
      slot_valid_q    <= 1'b0;
      slot_ir_q       <= 16'h0000;
      slot_pc_q       <= 16'h0000;
      slot_pc_plus2_q <= 16'h0000;
    end else begin
      state_q         <= state_d;
      fetch_pc_q      <= fetch_pc_d;
      pending_pc_q    <= pending_pc_d;
      hold_ir_q       <= hold_ir_d;
      hold_pc_q       <= hold_pc_d;
      slot_valid_q    <= slot_valid_d;
      slot_ir_q       <= slot_ir_d;
      slot_pc_q       <= slot_pc_d;
      slot_pc_plus2_q <= slot_pc_plus2_d;
    end
  end

  assign imem_read     = (state_q == S_FETCH) || (state_q == S_DISCARD);
  assign imem_address  = fetch_pc_q;
  assign if_valid      = slot_valid_q;
  assign if_ir         = slot_ir_q;
  assign if_pc         = slot_pc_q;
  assign if_pc_plus2   = slot_pc_plus2_q;
  assign if_opcode     = slot_ir_q[15:12];
  assign if_bits4_5_11 = {slot_ir_q[11], slot_ir_q[5], slot_ir_q[4]};

`ifdef LC3B_FETCH_PERF_EN
  logic [31:0] perf_bubbles_q;
  logic [31:0] perf_discards_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_bubbles_q  <= 32'h0;
      perf_discards_q <= 32'h0;
    end else begin
      if (!slot_valid_q && (perf_bubbles_q != 32'hFFFF_FFFF))
        perf_bubbles_q <= perf_bubbles_q + 32'd1;
      if (drop && (perf_discards_q != 32'hFFFF_FFFF))
        perf_discards_q <= perf_discards_q + 32'd1;
    end
  end

  assign perf_bubbles  = perf_bubbles_q;
  assign perf_discards = perf_discards_q;
`endif

endmodule
